dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Target (responder) side of the core's data-memory port.
- Accepts one load/store request at a time over a valid/ready request channel and applies a configurable number of wait states.
- Returns read data and an error flag over a valid/ready response channel.
- Replaces the zero-latency data_memory so that the core's load/store path can be exercised against realistic memory timing.

Parameters:
- DEPTH, 1024: number of 32-bit words in the array.
- LATENCY, 2: wait-state cycles between request acceptance and response; legal range 0..15.
- ADDR_W, 32: request byte-address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i enables byte i (little-endian).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset values (reset low, asynchronous):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch write, word index, wdata, be and the error flag.
  - Go to WAIT if LATENCY > 0, otherwise RESP.
- WAIT:
  - req_ready = 0.
  - Counter loads LATENCY-1 on acceptance and decrements each cycle.
  - Go to RESP when the counter is 0.
- RESP:
  - rsp_valid = 1 and rsp_rdata/rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
- Latency: rsp_valid rises exactly LATENCY+1 clocks after the acceptance edge.
- Throughput: at most one request per (LATENCY+2) cycles. Requests are not accepted in the same cycle a response completes.
- Error rule: err = (req_addr[1:0] != 0) || (req_addr[ADDR_W-1:2] >= DEPTH).
  - An erroring request performs no array write.
  - It returns rdata = 0 and err = 1 with normal timing.
- Store:
  - Committed on the edge entering RESP; only bytes with be[i] = 1 are updated.
  - be = 0 is legal: no change, err = 0.
  - Response carries rdata = 0.
- Load:
  - The full word is sampled on the edge entering RESP; req_be is ignored.
  - A load issued after a completed store to the same word returns the merged store data.
- Request inputs are don't-care while req_ready = 0. They are not re-sampled, so a change after acceptance has no effect.
- rsp_ready held high before RESP has no effect.
- reset asserted mid-transaction:
  - Pending transaction dropped, FSM returns to IDLE, no rsp_valid.
  - A store not yet committed (still in WAIT) is not written.
- Word index uses req_addr[log2(DEPTH)+1:2]. No wrap-around: out-of-range indices are errors, not aliases.

Decomposition:
- Shared package mem_pkg:
  - XLEN = 32.
  - Enum mem_state_t {IDLE, WAIT, RESP}.
  - Packed struct mem_req_t {write, word index, wdata, be, err}.
  - Shared by the core-side load/store initiator.
- One sub-module, dmem_array: synchronous single-port 32-bit word array with a per-byte write-enable. dmem_responder owns the FSM, counter and error check.

Test Plan:
- Reset then idle: reset low for 3 cycles, release → req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Store then load, LATENCY = 2:
  - Store addr 0x10, wdata 0xDEADBEEF, be 4'hF → rsp_valid exactly 3 clocks after acceptance, rdata 0, err 0.
  - Load addr 0x10 → rdata 0xDEADBEEF.
- Byte enables: after the above, store addr 0x10, wdata 0x11223344, be 4'b0101 → subsequent load returns 0xDE22BE44.
- Errors:
  - Load addr 0x13 → err 1, rdata 0, same latency.
  - Store to addr 4*DEPTH → err 1, and a later load of word 0 is unchanged.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP → rsp_valid, rdata and err stable; req_ready stays 0 even with req_valid = 1; completion on rsp_ready = 1.
- Reset in WAIT and LATENCY = 0:
  - Store 0xCAFEF00D to addr 0x20, assert reset during WAIT → no response, and a later load of 0x20 returns the prior value.
  - Rerun the store/load pair with LATENCY = 0 → rsp_valid 1 clock after acceptance.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the data-memory request/response path
package mem_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  typedef struct packed {
    logic            write;
    logic [XLEN-3:0] idx;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic            err;
  } mem_req_t;
endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - synchronous single-port word array with per-byte write enables
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata
);
  logic [XLEN-1:0] mem [DEPTH];

  // rdata only moves on reads, so it holds the last load while a response waits
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with configurable wait states
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  mem_state_t      state, next;
  mem_req_t        held, in_req, act;
  logic [3:0]      cnt;
  logic            accept, enter_resp, mem_en;
  logic [XLEN-1:0] arr_rdata;

  always_comb begin
    in_req       = '0;
    in_req.write = req_write;
    in_req.idx   = (XLEN-2)'(req_addr[IDX_W+1:2]);
    in_req.wdata = req_wdata;
    in_req.be    = req_be;
    in_req.err   = (req_addr[1:0] != 2'b00) ||
                   (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
  end

  assign accept = req_valid && (state == IDLE);
  // with zero latency the access happens on the acceptance edge, before held is loaded
  assign act    = (state == IDLE) ? in_req : held;

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) next = RESP;
      RESP:    if (rsp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign enter_resp = (next == RESP) && (state != RESP);
  assign mem_en     = enter_resp && !act.err && (act.idx < (XLEN-2)'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      held  <= '0;
      cnt   <= 4'd0;
    end else begin
      state <= next;
      if (accept) begin
        held <= in_req;
        cnt  <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (act.write),
    .be    (act.be),
    .idx   (act.idx[IDX_W-1:0]),
    .wdata (act.wdata),
    .rdata (arr_rdata)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && held.err;
  assign rsp_rdata = (state == RESP && !held.write && !held.err) ? arr_rdata : '0;
endmodule
